// File: rtl/mux_sel_serializer_if.sv
// Handshake bundle between the parallel-word source, the select serializer and the serial sink.
// The master is whoever drives the parallel word and accepts the serial stream.
interface mux_sel_serializer_if #(
    parameter int WIDTH = 4
);
    localparam int SEL_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_bit;
    logic             ser_last;
    logic [SEL_W-1:0] sel;
    logic             busy;

    modport master (
        output in_valid, in_data, ser_ready,
        input  in_ready, ser_valid, ser_bit, ser_last, sel, busy
    );

    modport slave (
        input  in_valid, in_data, ser_ready,
        output in_ready, ser_valid, ser_bit, ser_last, sel, busy
    );
endinterface

// File: rtl/mux_sel_serializer.sv
// Select sequencer for the 4:1 mux stage: captures a parallel word, then walks the
// select index across it and streams the chosen bit out over a serial valid/ready link.
module mux_sel_serializer #(
    parameter int WIDTH     = 4,
    parameter int SEL_W     = $clog2(WIDTH),
    parameter int MSB_FIRST = 0
) (
    input logic                clk,
    input logic                rst,
    mux_sel_serializer_if.slave bus
);
    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q,  word_d;
    logic [SEL_W-1:0] cnt_q,   cnt_d;
    logic [SEL_W-1:0] selIdx;
    logic             lastBit;

    assign lastBit = (cnt_q == LAST_IDX);
    assign selIdx  = (MSB_FIRST != 0) ? (LAST_IDX - cnt_q) : cnt_q;

    // The word-complete beat doubles as the load slot, so a waiting word follows with no bubble.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    word_d  = bus.in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.ser_ready) begin
                    if (!lastBit) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (bus.in_valid) begin
                        word_d = bus.in_data;
                        cnt_d  = '0;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) ? 1'b1 : (bus.ser_ready && lastBit);
    assign bus.ser_valid = (state_q == SHIFT);
    assign bus.busy      = (state_q == SHIFT);
    assign bus.ser_last  = (state_q == SHIFT) && lastBit;
    assign bus.sel       = selIdx;
    assign bus.ser_bit   = word_q[selIdx];
endmodule

// File: tb/tb_mux_sel_serializer.sv
// Directed bench for mux_sel_serializer: an ascending and a descending instance share one
// stimulus stream, and each beat is checked against hand-derived select/bit/last values.
module tb_mux_sel_serializer;
    logic       clk;
    logic       rst;
    logic       inValid;
    logic [3:0] inData;
    logic       serReady;
    bit         useMsb;
    int         checks;
    int         errors;
    int         xferCount;

    mux_sel_serializer_if #(.WIDTH(4)) if0 ();
    mux_sel_serializer_if #(.WIDTH(4)) if1 ();

    assign if0.in_valid  = inValid;
    assign if0.in_data   = inData;
    assign if0.ser_ready = serReady;
    assign if1.in_valid  = inValid;
    assign if1.in_data   = inData;
    assign if1.ser_ready = serReady;

    mux_sel_serializer #(.WIDTH(4), .MSB_FIRST(0)) dutLsb (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    mux_sel_serializer #(.WIDTH(4), .MSB_FIRST(1)) dutMsb (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    logic       oValid, oReady, oBit, oLast, oBusy;
    logic [1:0] oSel;

    assign oValid = useMsb ? if1.ser_valid : if0.ser_valid;
    assign oReady = useMsb ? if1.in_ready  : if0.in_ready;
    assign oBit   = useMsb ? if1.ser_bit   : if0.ser_bit;
    assign oLast  = useMsb ? if1.ser_last  : if0.ser_last;
    assign oBusy  = useMsb ? if1.busy      : if0.busy;
    assign oSel   = useMsb ? if1.sel       : if0.sel;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] d, input logic r);
        inValid  = v;
        inData   = d;
        serReady = r;
    endtask

    // One serial beat: check the presented bit, then advance a clock.
    task automatic expectBeat(input string tag, input int s, input int b, input int l, input int rdy);
        checkOutput({tag, ".valid"}, int'(oValid), 1);
        checkOutput({tag, ".busy"},  int'(oBusy),  1);
        checkOutput({tag, ".sel"},   int'(oSel),   s);
        checkOutput({tag, ".bit"},   int'(oBit),   b);
        checkOutput({tag, ".last"},  int'(oLast),  l);
        if (rdy >= 0) checkOutput({tag, ".inrdy"}, int'(oReady), rdy);
        if (serReady) xferCount++;
        tick();
    endtask

    task automatic expectIdle(input string tag);
        checkOutput({tag, ".valid"}, int'(oValid), 0);
        checkOutput({tag, ".inrdy"}, int'(oReady), 1);
        checkOutput({tag, ".busy"},  int'(oBusy),  0);
        checkOutput({tag, ".last"},  int'(oLast),  0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        xferCount = 0;
        useMsb    = 1'b0;
        applyStimulus(1'b0, 4'b0000, 1'b1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        expectIdle("rst");
        checkOutput("rst.bit",  int'(oBit), 0);
        checkOutput("rst.sel0", int'(if0.sel), 0);
        checkOutput("rst.sel1", int'(if1.sel), 3);

        // Ascending sweep of 1010.
        applyStimulus(1'b1, 4'b1010, 1'b1);
        tick();
        inValid = 1'b0;
        expectBeat("t1.b0", 0, 0, 0, 0);
        expectBeat("t1.b1", 1, 1, 0, 0);
        expectBeat("t1.b2", 2, 0, 0, 0);
        expectBeat("t1.b3", 3, 1, 1, 1);
        expectIdle("t1.end");

        // Descending sweep of 0110.
        useMsb = 1'b1;
        applyStimulus(1'b1, 4'b0110, 1'b1);
        tick();
        inValid = 1'b0;
        expectBeat("t2.b0", 3, 0, 0, 0);
        expectBeat("t2.b1", 2, 1, 0, 0);
        expectBeat("t2.b2", 1, 1, 0, 0);
        expectBeat("t2.b3", 0, 0, 1, 1);
        expectIdle("t2.end");
        useMsb = 1'b0;

        // Back-to-back words with in_valid held high.
        applyStimulus(1'b1, 4'b1010, 1'b1);
        tick();
        inData = 4'b0110;
        expectBeat("t3.w1b0", 0, 0, 0, 0);
        expectBeat("t3.w1b1", 1, 1, 0, 0);
        expectBeat("t3.w1b2", 2, 0, 0, 0);
        expectBeat("t3.w1b3", 3, 1, 1, 1);
        expectBeat("t3.w2b0", 0, 0, 0, 0);
        inValid = 1'b0;
        expectBeat("t3.w2b1", 1, 1, 0, 0);
        expectBeat("t3.w2b2", 2, 1, 0, 0);
        expectBeat("t3.w2b3", 3, 0, 1, -1);
        expectIdle("t3.end");

        // Three stall cycles at index 2.
        xferCount = 0;
        applyStimulus(1'b1, 4'b1010, 1'b1);
        tick();
        inValid = 1'b0;
        expectBeat("t4.b0", 0, 0, 0, 0);
        expectBeat("t4.b1", 1, 1, 0, 0);
        serReady = 1'b0;
        for (int i = 0; i < 3; i++) expectBeat("t4.hold", 2, 0, 0, 0);
        serReady = 1'b1;
        expectBeat("t4.b2", 2, 0, 0, 0);
        expectBeat("t4.b3", 3, 1, 1, 1);
        expectIdle("t4.end");
        checkOutput("t4.xfers", xferCount, 4);

        // Reset in the middle of a word, then reset colliding with a handshake.
        applyStimulus(1'b1, 4'b1111, 1'b1);
        tick();
        inValid = 1'b0;
        expectBeat("t5.b0", 0, 1, 0, 0);
        checkOutput("t5.midsel", int'(oSel), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expectIdle("t5.rst");
        checkOutput("t5.rstbit", int'(oBit), 0);
        rst = 1'b1;
        applyStimulus(1'b1, 4'b1111, 1'b1);
        tick();
        rst     = 1'b0;
        inValid = 1'b0;
        tick();
        expectIdle("t5.rstwin");
        checkOutput("t5.rstwinbit", int'(oBit), 0);
        applyStimulus(1'b1, 4'b0001, 1'b1);
        tick();
        inValid = 1'b0;
        expectBeat("t5.b0n", 0, 1, 0, 0);
        expectBeat("t5.b1n", 1, 0, 0, 0);
        expectBeat("t5.b2n", 2, 0, 0, 0);
        expectBeat("t5.b3n", 3, 0, 1, 1);
        expectIdle("t5.end");

        // in_data changes after capture must not disturb the word in flight.
        applyStimulus(1'b1, 4'b1010, 1'b1);
        tick();
        inValid = 1'b0;
        inData  = 4'b0000;
        expectBeat("t6.b0", 0, 0, 0, 0);
        expectBeat("t6.b1", 1, 1, 0, 0);
        expectBeat("t6.b2", 2, 0, 0, 0);
        expectBeat("t6.b3", 3, 1, 1, 1);
        expectIdle("t6.end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
